// File: rtl/commit_stage.sv
// rtl/commit_stage.sv - retirement stage: load wait, trap arbitration, regfile/CSR write-back
// Optional COMMIT_INSTRET_EN adds a 64-bit retired-instruction counter output.
module commit_stage #(
  parameter int XLEN     = 32,
  parameter int TRAP_GAP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid5,
  input  logic            we5,
  input  logic [4:0]      rd5,
  input  logic [XLEN-1:0] result5,
  input  logic            load5,
  input  logic            mem_done,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            csr_we5,
  input  logic [11:0]     csr_addr5,
  input  logic [XLEN-1:0] csr_wdata5,
  input  logic [XLEN-1:0] pc5,
  input  logic            misalign5,
  input  logic            illegal5,
  input  logic            ecall5,
  input  logic            ebreak5,
  input  logic            mret5,
  input  logic            sret5,
  input  logic            uret5,
  input  logic [1:0]      current_mode,
  input  logic            irq_pending,
  input  logic [XLEN-1:0] irq_cause,
  output logic            we6,
  output logic [4:0]      rdaddr6,
  output logic [XLEN-1:0] wb6,
  output logic            csr_we6,
  output logic [11:0]     csr_wb_addr,
  output logic [XLEN-1:0] csr_wb,
  output logic            exception_pending,
  output logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] pc_exc,
  output logic            m_ret,
  output logic            s_ret,
  output logic            u_ret,
  output logic            exception,
  output logic            stall_commit
`ifdef COMMIT_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  typedef enum logic [1:0] {RUN, WAIT_MEM, TRAP} state_t;

  state_t          state;
  logic [1:0]      gap_cnt;
  logic [4:0]      held_rd;
  logic            held_we;
  logic            take_trap;
  logic [XLEN-1:0] trap_cause;

  assign take_trap = valid5 && (irq_pending || misalign5 || illegal5 || ecall5 || ebreak5);

  // Interrupt outranks every synchronous exception; ecall from the reserved mode is illegal.
  always_comb begin
    trap_cause = '0;
    if (irq_pending)    trap_cause = irq_cause;
    else if (misalign5) trap_cause = XLEN'(0);
    else if (illegal5)  trap_cause = XLEN'(2);
    else if (ecall5) begin
      case (current_mode)
        2'd0:    trap_cause = XLEN'(8);
        2'd1:    trap_cause = XLEN'(9);
        2'd3:    trap_cause = XLEN'(11);
        default: trap_cause = XLEN'(2);
      endcase
    end
    else if (ebreak5)   trap_cause = XLEN'(3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RUN;
      gap_cnt           <= '0;
      held_rd           <= '0;
      held_we           <= 1'b0;
      we6               <= 1'b0;
      rdaddr6           <= '0;
      wb6               <= '0;
      csr_we6           <= 1'b0;
      csr_wb_addr       <= '0;
      csr_wb            <= '0;
      exception_pending <= 1'b0;
      exception         <= 1'b0;
      cause             <= '0;
      pc_exc            <= '0;
      m_ret             <= 1'b0;
      s_ret             <= 1'b0;
      u_ret             <= 1'b0;
      stall_commit      <= 1'b0;
`ifdef COMMIT_INSTRET_EN
      instret           <= '0;
`endif
    end else begin
      we6               <= 1'b0;
      rdaddr6           <= '0;
      wb6               <= '0;
      csr_we6           <= 1'b0;
      csr_wb_addr       <= '0;
      csr_wb            <= '0;
      exception_pending <= 1'b0;
      exception         <= 1'b0;
      cause             <= '0;
      pc_exc            <= '0;
      m_ret             <= 1'b0;
      s_ret             <= 1'b0;
      u_ret             <= 1'b0;
      case (state)
        RUN: begin
          stall_commit <= 1'b0;
          if (take_trap) begin
            exception_pending <= 1'b1;
            exception         <= 1'b1;
            cause             <= trap_cause;
            pc_exc            <= pc5;
            gap_cnt           <= '0;
            state             <= TRAP;
          end else if (valid5 && load5 && !mem_done) begin
            held_rd      <= rd5;
            held_we      <= we5;
            stall_commit <= 1'b1;
            state        <= WAIT_MEM;
          end else if (valid5) begin
            we6         <= we5 && (rd5 != 5'd0);
            rdaddr6     <= rd5;
            wb6         <= load5 ? mem_rdata : result5;
            csr_we6     <= csr_we5;
            csr_wb_addr <= csr_addr5;
            csr_wb      <= csr_wdata5;
            m_ret       <= mret5;
            s_ret       <= sret5;
            u_ret       <= uret5;
`ifdef COMMIT_INSTRET_EN
            instret     <= instret + 64'd1;
`endif
          end
        end
        WAIT_MEM: begin
          if (mem_done) begin
            we6          <= held_we && (held_rd != 5'd0);
            rdaddr6      <= held_rd;
            wb6          <= mem_rdata;
            stall_commit <= 1'b0;
            state        <= RUN;
`ifdef COMMIT_INSTRET_EN
            instret      <= instret + 64'd1;
`endif
          end
        end
        TRAP: begin
          stall_commit <= 1'b0;
          if (gap_cnt >= 2'(TRAP_GAP - 1)) state <= RUN;
          if (gap_cnt != 2'd3) gap_cnt <= gap_cnt + 2'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// tb/tb_commit_stage.sv - directed and randomized check of commit_stage against a transaction model
module tb_commit_stage;
  localparam int XLEN = 32;
  localparam int TG   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, valid5, we5, load5, mem_done, csr_we5;
  logic [4:0] rd5;
  logic [XLEN-1:0] result5, mem_rdata, csr_wdata5, pc5, irq_cause;
  logic [11:0] csr_addr5;
  logic misalign5, illegal5, ecall5, ebreak5, mret5, sret5, uret5, irq_pending;
  logic [1:0] current_mode;
  logic we6, csr_we6, exception_pending, m_ret, s_ret, u_ret, exception, stall_commit;
  logic [4:0] rdaddr6;
  logic [XLEN-1:0] wb6, csr_wb, cause, pc_exc;
  logic [11:0] csr_wb_addr;
  logic [63:0] instret_obs;
`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret;
  assign instret_obs = instret;
`else
  assign instret_obs = 64'd0;
`endif

  commit_stage #(.XLEN(XLEN), .TRAP_GAP(TG)) dut (
    .clk(clk), .rst(rst), .valid5(valid5), .we5(we5), .rd5(rd5), .result5(result5),
    .load5(load5), .mem_done(mem_done), .mem_rdata(mem_rdata), .csr_we5(csr_we5),
    .csr_addr5(csr_addr5), .csr_wdata5(csr_wdata5), .pc5(pc5), .misalign5(misalign5),
    .illegal5(illegal5), .ecall5(ecall5), .ebreak5(ebreak5), .mret5(mret5), .sret5(sret5),
    .uret5(uret5), .current_mode(current_mode), .irq_pending(irq_pending),
    .irq_cause(irq_cause), .we6(we6), .rdaddr6(rdaddr6), .wb6(wb6), .csr_we6(csr_we6),
    .csr_wb_addr(csr_wb_addr), .csr_wb(csr_wb), .exception_pending(exception_pending),
    .cause(cause), .pc_exc(pc_exc), .m_ret(m_ret), .s_ret(s_ret), .u_ret(u_ret),
    .exception(exception), .stall_commit(stall_commit)
`ifdef COMMIT_INSTRET_EN
    , .instret(instret)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: pending load, remaining blind cycles after a trap, retirement count.
  bit          m_wait;
  logic [4:0]  m_rd;
  bit          m_we;
  int          m_blind;
  logic [63:0] m_instret;

  logic e_we, e_csr_we, e_exc, e_mret, e_sret, e_uret, e_stall;
  logic [4:0] e_rdaddr;
  logic [XLEN-1:0] e_wb, e_csr_wb, e_cause, e_pc_exc;
  logic [11:0] e_csr_addr;

  function automatic logic [XLEN-1:0] exc_code();
    if (irq_pending) return irq_cause;
    if (misalign5)   return 0;
    if (illegal5)    return 2;
    if (ecall5)      return (current_mode == 2'd0) ? 8 : (current_mode == 2'd1) ? 9 :
                            (current_mode == 2'd3) ? 11 : 2;
    return 3;
  endfunction

  task automatic predict();
    e_we = 0; e_csr_we = 0; e_exc = 0; e_mret = 0; e_sret = 0; e_uret = 0; e_stall = 0;
    e_rdaddr = 0; e_wb = 0; e_csr_wb = 0; e_cause = 0; e_pc_exc = 0; e_csr_addr = 0;
    if (rst) begin
      m_wait = 0; m_blind = 0; m_instret = 0;
    end else if (m_blind > 0) begin
      m_blind--;
    end else if (m_wait) begin
      if (mem_done) begin
        e_we = m_we && (m_rd != 0); e_rdaddr = m_rd; e_wb = mem_rdata;
        m_wait = 0; m_instret++;
      end else e_stall = 1;
    end else if (valid5) begin
      if (irq_pending || misalign5 || illegal5 || ecall5 || ebreak5) begin
        e_exc = 1; e_cause = exc_code(); e_pc_exc = pc5; m_blind = TG;
      end else if (load5 && !mem_done) begin
        m_wait = 1; m_rd = rd5; m_we = we5; e_stall = 1;
      end else begin
        e_we = we5 && (rd5 != 0); e_rdaddr = rd5; e_wb = load5 ? mem_rdata : result5;
        e_csr_we = csr_we5; e_csr_addr = csr_addr5; e_csr_wb = csr_wdata5;
        e_mret = mret5; e_sret = sret5; e_uret = uret5; m_instret++;
      end
    end
  endtask

  task automatic cycle();
    predict();
    @(posedge clk); #1;
    check("we6", 64'(we6), 64'(e_we));
    check("rdaddr6", 64'(rdaddr6), 64'(e_rdaddr));
    check("wb6", 64'(wb6), 64'(e_wb));
    check("csr_we6", 64'(csr_we6), 64'(e_csr_we));
    check("csr_wb_addr", 64'(csr_wb_addr), 64'(e_csr_addr));
    check("csr_wb", 64'(csr_wb), 64'(e_csr_wb));
    check("exception_pending", 64'(exception_pending), 64'(e_exc));
    check("exception", 64'(exception), 64'(e_exc));
    check("cause", 64'(cause), 64'(e_cause));
    check("pc_exc", 64'(pc_exc), 64'(e_pc_exc));
    check("m_ret", 64'(m_ret), 64'(e_mret));
    check("s_ret", 64'(s_ret), 64'(e_sret));
    check("u_ret", 64'(u_ret), 64'(e_uret));
    check("stall_commit", 64'(stall_commit), 64'(e_stall));
`ifdef COMMIT_INSTRET_EN
    check("instret", instret_obs, m_instret);
`endif
  endtask

  task automatic idle();
    rst = 0; valid5 = 0; we5 = 0; rd5 = 0; result5 = 0; load5 = 0; mem_done = 0;
    mem_rdata = 0; csr_we5 = 0; csr_addr5 = 0; csr_wdata5 = 0; pc5 = 0;
    misalign5 = 0; illegal5 = 0; ecall5 = 0; ebreak5 = 0; mret5 = 0; sret5 = 0; uret5 = 0;
    current_mode = 2'd3; irq_pending = 0; irq_cause = 0;
  endtask

  initial begin
    m_wait = 0; m_rd = 0; m_we = 0; m_blind = 0; m_instret = 0;
    idle(); rst = 1;
    cycle(); cycle();
    idle();

    // plain write-back
    valid5 = 1; we5 = 1; rd5 = 5; result5 = 32'hDEAD_BEEF; cycle();
    idle(); cycle();

    // load waiting three cycles on memory
    valid5 = 1; we5 = 1; rd5 = 7; load5 = 1; cycle();
    idle(); irq_pending = 1; irq_cause = 32'h8000_0003; cycle(); cycle();
    idle(); mem_done = 1; mem_rdata = 32'h1234; cycle();
    idle(); cycle();

    // ecall from M-mode, then valid5 with a write ignored during the gap
    valid5 = 1; we5 = 1; rd5 = 3; ecall5 = 1; current_mode = 2'd3; pc5 = 32'h80; cycle();
    idle(); valid5 = 1; we5 = 1; rd5 = 4; result5 = 32'h55; cycle(); cycle();
    cycle();
    idle();

    // interrupt outranks simultaneous illegal and ecall
    valid5 = 1; illegal5 = 1; ecall5 = 1; irq_pending = 1; irq_cause = 32'h8000_0007;
    pc5 = 32'h100; cycle();
    idle(); cycle(); cycle(); cycle();

    // ecall in reserved mode, ebreak, misaligned load never waits
    valid5 = 1; ecall5 = 1; current_mode = 2'd2; cycle(); idle(); cycle(); cycle();
    valid5 = 1; ebreak5 = 1; cycle(); idle(); cycle(); cycle();
    valid5 = 1; load5 = 1; misalign5 = 1; we5 = 1; rd5 = 9; cycle(); idle(); cycle(); cycle();

    // x0 destination and mret
    valid5 = 1; we5 = 1; rd5 = 0; result5 = 32'h77; cycle();
    idle(); valid5 = 1; mret5 = 1; cycle();
    idle(); cycle();

    // reset in the middle of a load wait discards it
    valid5 = 1; we5 = 1; rd5 = 12; load5 = 1; cycle();
    idle(); cycle();
    rst = 1; cycle();
    idle(); mem_done = 1; mem_rdata = 32'hCAFE; cycle();
    idle();

    // four retirements
    for (int i = 0; i < 4; i++) begin
      valid5 = 1; we5 = 1; rd5 = 5'(i + 1); result5 = i; cycle();
    end
    idle(); cycle();

    for (int i = 0; i < 600; i++) begin
      idle();
      rst          = ($urandom_range(0, 49) == 0);
      valid5       = ($urandom_range(0, 1) == 1);
      we5          = ($urandom_range(0, 3) != 0);
      rd5          = 5'($urandom_range(0, 31));
      result5      = $urandom();
      load5        = ($urandom_range(0, 2) == 0);
      mem_done     = ($urandom_range(0, 1) == 1);
      mem_rdata    = $urandom();
      pc5          = $urandom();
      current_mode = 2'($urandom_range(0, 3));
      misalign5    = ($urandom_range(0, 15) == 0);
      illegal5     = ($urandom_range(0, 15) == 0);
      ecall5       = ($urandom_range(0, 15) == 0);
      ebreak5      = ($urandom_range(0, 15) == 0);
      irq_pending  = ($urandom_range(0, 9) == 0);
      irq_cause    = {1'b1, 31'($urandom_range(0, 15))};
      if (!load5) begin
        csr_we5    = ($urandom_range(0, 3) == 0);
        csr_addr5  = 12'($urandom_range(0, 4095));
        csr_wdata5 = $urandom();
        case ($urandom_range(0, 7))
          0: mret5 = 1;
          1: sret5 = 1;
          2: uret5 = 1;
          default: ;
        endcase
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
